// File: rtl/store_buffer.sv
// Store buffer: speculative queue feeding a commit queue that drains one store
// at a time to the data bus, with store-to-load forwarding across both queues.
module store_buffer #(
    parameter int unsigned SPEC_DEPTH   = 4,
    parameter int unsigned COMMIT_DEPTH = 4,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned TAG_W        = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [1:0]        st_size_i,
    input  logic [63:0]       st_data_i,
    input  logic              st_ex_i,
    input  logic [TAG_W-1:0]  st_tag_i,
    input  logic              commit_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_be_i,
    output logic              ld_wait_o,
    output logic              ld_fwd_valid_o,
    output logic [63:0]       ld_fwd_data_o,
    output logic              d_req_o,
    output logic [ADDR_W-1:0] d_addr_o,
    output logic [7:0]        d_be_o,
    output logic [63:0]       d_data_o,
    input  logic              d_ack_i,
    input  logic              d_err_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              res_err_o
);

    localparam int unsigned SAW = $clog2(SPEC_DEPTH);
    localparam int unsigned CAW = $clog2(COMMIT_DEPTH);
    localparam int unsigned SPW = SAW + 1;
    localparam int unsigned CPW = CAW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        be;
        logic [63:0]       data;
        logic              ex;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    entry_t         r_spec_q [SPEC_DEPTH];
    entry_t         r_com_q  [COMMIT_DEPTH];
    logic [SAW:0]   r_spec_wp, r_spec_rp;
    logic [CAW:0]   r_com_wp, r_com_rp;
    state_t         r_state, w_next;
    logic           r_err;

    logic [SAW:0]   w_spec_cnt;
    logic [CAW:0]   w_com_cnt;
    logic           w_spec_empty, w_spec_full, w_com_empty, w_com_full;
    logic           w_push, w_move, w_pop;
    logic [15:0]    w_st_mask;
    entry_t         w_st_entry, w_head;
    logic [SAW-1:0] w_s_idx;
    logic [CAW-1:0] w_c_idx;
    logic           w_any, w_hit_ex, w_fwd;
    logic [7:0]     w_hit_be;
    logic [63:0]    w_hit_data, w_ld_mask;

    function automatic logic f_overlap(entry_t e, logic [ADDR_W-1:0] a, logic [7:0] be);
        return (e.addr[ADDR_W-1:3] == a[ADDR_W-1:3]) && ((e.be & be) != '0);
    endfunction

    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    assign w_spec_cnt   = r_spec_wp - r_spec_rp;
    assign w_com_cnt    = r_com_wp - r_com_rp;
    assign w_spec_empty = (r_spec_wp == r_spec_rp);
    assign w_spec_full  = (r_spec_wp[SAW] != r_spec_rp[SAW]) &&
                          (r_spec_wp[SAW-1:0] == r_spec_rp[SAW-1:0]);
    assign w_com_empty  = (r_com_wp == r_com_rp);
    assign w_com_full   = (r_com_wp[CAW] != r_com_rp[CAW]) &&
                          (r_com_wp[CAW-1:0] == r_com_rp[CAW-1:0]);

    assign st_ready_o = ~w_spec_full;
    assign w_push     = st_valid_i & ~w_spec_full & ~flush_i;
    assign w_move     = commit_i & ~w_spec_empty & ~w_com_full;
    assign w_pop      = (r_state == S_RESP) & res_ready_i;
    assign w_head     = r_com_q[r_com_rp[CAW-1:0]];

    always_comb begin
        w_st_mask       = ((16'd1 << (5'd1 << st_size_i)) - 16'd1) << st_addr_i[2:0];
        w_st_entry.addr = st_addr_i;
        w_st_entry.be   = w_st_mask[7:0];
        w_st_entry.data = st_data_i;
        w_st_entry.ex   = st_ex_i;
        w_st_entry.tag  = st_tag_i;
    end

    // Flush empties the speculative queue; a same-cycle commit still copies the head out first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_spec_wp <= '0;
            r_spec_rp <= '0;
            r_com_wp  <= '0;
            r_com_rp  <= '0;
        end else begin
            if (flush_i)     r_spec_rp <= r_spec_wp;
            else if (w_move) r_spec_rp <= r_spec_rp + 1'b1;
            if (w_push)      r_spec_wp <= r_spec_wp + 1'b1;
            if (w_move)      r_com_wp  <= r_com_wp + 1'b1;
            if (w_pop)       r_com_rp  <= r_com_rp + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_spec_q[r_spec_wp[SAW-1:0]] <= w_st_entry;
        if (w_move) r_com_q[r_com_wp[CAW-1:0]]   <= r_spec_q[r_spec_rp[SAW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                         r_err <= 1'b0;
        else if ((r_state == S_IDLE) && !w_com_empty)        r_err <= w_head.ex;
        else if ((r_state == S_REQ) && d_ack_i)              r_err <= d_err_i;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_com_empty) w_next = w_head.ex ? S_RESP : S_REQ;
            S_REQ:   if (d_ack_i)      w_next = S_RESP;
            S_RESP:  if (res_ready_i)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        d_req_o     = 1'b0;
        d_addr_o    = '0;
        d_be_o      = '0;
        d_data_o    = '0;
        res_valid_o = 1'b0;
        res_tag_o   = '0;
        res_err_o   = 1'b0;
        if (r_state == S_REQ) begin
            d_req_o  = 1'b1;
            d_addr_o = w_head.addr;
            d_be_o   = w_head.be;
            d_data_o = w_head.data;
        end
        if (r_state == S_RESP) begin
            res_valid_o = 1'b1;
            res_tag_o   = w_head.tag;
            res_err_o   = r_err;
        end
    end

    // Oldest-to-youngest scan, committed before speculative, so the last hit is the youngest.
    always_comb begin
        w_any      = 1'b0;
        w_hit_ex   = 1'b0;
        w_hit_be   = '0;
        w_hit_data = '0;
        w_c_idx    = '0;
        w_s_idx    = '0;
        for (int unsigned k = 0; k < COMMIT_DEPTH; k++) begin
            w_c_idx = r_com_rp[CAW-1:0] + CAW'(k);
            if ((CPW'(k) < w_com_cnt) && f_overlap(r_com_q[w_c_idx], ld_addr_i, ld_be_i)) begin
                w_any      = 1'b1;
                w_hit_ex   = r_com_q[w_c_idx].ex;
                w_hit_be   = r_com_q[w_c_idx].be;
                w_hit_data = r_com_q[w_c_idx].data;
            end
        end
        for (int unsigned k = 0; k < SPEC_DEPTH; k++) begin
            w_s_idx = r_spec_rp[SAW-1:0] + SAW'(k);
            if ((SPW'(k) < w_spec_cnt) && f_overlap(r_spec_q[w_s_idx], ld_addr_i, ld_be_i)) begin
                w_any      = 1'b1;
                w_hit_ex   = r_spec_q[w_s_idx].ex;
                w_hit_be   = r_spec_q[w_s_idx].be;
                w_hit_data = r_spec_q[w_s_idx].data;
            end
        end
    end

    always_comb begin
        w_ld_mask = '0;
        for (int unsigned b = 0; b < 8; b++) w_ld_mask[b*8 +: 8] = {8{ld_be_i[b]}};
    end

    assign w_fwd          = w_any & ~w_hit_ex & ((w_hit_be & ld_be_i) == ld_be_i);
    assign ld_fwd_valid_o = w_fwd;
    assign ld_wait_o      = w_any & ~w_fwd;
    assign ld_fwd_data_o  = w_fwd ? (w_hit_data & w_ld_mask) : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-level reference model predicts
// forwarding, bus requests and results; a negedge monitor compares.
module tb_store_buffer;

    localparam int SD = 4;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, st_valid_i, st_ready_o, st_ex_i, commit_i;
    logic [63:0] st_addr_i, st_data_i, ld_addr_i, ld_fwd_data_o;
    logic [1:0]  st_size_i;
    logic [2:0]  st_tag_i, res_tag_o;
    logic [7:0]  ld_be_i, d_be_o;
    logic        ld_wait_o, ld_fwd_valid_o, d_req_o, d_ack_i, d_err_i;
    logic [63:0] d_addr_o, d_data_o;
    logic        res_valid_o, res_ready_i, res_err_o;

    always #5 clk = ~clk;

    store_buffer #(.SPEC_DEPTH(SD), .COMMIT_DEPTH(CD), .ADDR_W(64), .TAG_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
        .st_size_i(st_size_i), .st_data_i(st_data_i), .st_ex_i(st_ex_i), .st_tag_i(st_tag_i),
        .commit_i(commit_i), .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i),
        .ld_wait_o(ld_wait_o), .ld_fwd_valid_o(ld_fwd_valid_o), .ld_fwd_data_o(ld_fwd_data_o),
        .d_req_o(d_req_o), .d_addr_o(d_addr_o), .d_be_o(d_be_o), .d_data_o(d_data_o),
        .d_ack_i(d_ack_i), .d_err_i(d_err_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_tag_o(res_tag_o), .res_err_o(res_err_o)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic        ex;
        logic [2:0]  tag;
    } ent_t;
    typedef struct {
        logic [2:0] tag;
        logic       err;
    } res_t;

    ent_t spec_q[$];
    ent_t com_q[$];
    ent_t bus_exp[$];
    res_t res_exp[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    bit man_mode = 1'b0;
    logic man_ack = 1'b0, man_err = 1'b0, man_rdy = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_be(input logic [63:0] a, input logic [1:0] sz);
        int nbytes = 1 << sz;
        int off = int'(a[2:0]);
        logic [7:0] be = '0;
        for (int b = 0; b < 8; b++) if (b >= off && b < off + nbytes) be[b] = 1'b1;
        return be;
    endfunction

    // Youngest matching store wins; committed stores are older than speculative ones.
    function automatic void model_ld(input logic [63:0] la, input logic [7:0] lbe,
                                     output logic w, output logic fv, output logic [63:0] fd);
        ent_t all[$];
        w = 1'b0; fv = 1'b0; fd = '0;
        foreach (com_q[i])  all.push_back(com_q[i]);
        foreach (spec_q[i]) all.push_back(spec_q[i]);
        for (int i = all.size() - 1; i >= 0; i--) begin
            if (all[i].addr[63:3] == la[63:3] && (all[i].be & lbe) != 8'h00) begin
                if (!all[i].ex && (all[i].be & lbe) == lbe) begin
                    fv = 1'b1;
                    for (int b = 0; b < 8; b++) if (lbe[b]) fd[b*8 +: 8] = all[i].data[b*8 +: 8];
                end else begin
                    w = 1'b1;
                end
                break;
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        logic ew, efv;
        logic [63:0] efd;
        bit mv, ps, hs;
        ent_t e;
        if (mon_en && rst_n) begin
            model_ld(ld_addr_i, ld_be_i, ew, efv, efd);
            check("ld_wait", 64'(ld_wait_o), 64'(ew));
            check("ld_fwd_valid", 64'(ld_fwd_valid_o), 64'(efv));
            check("ld_fwd_data", ld_fwd_data_o, efd);
            check("st_ready", 64'(st_ready_o), 64'(spec_q.size() < SD));
            if (d_req_o) begin
                if (bus_exp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL d_req_unexpected: got request addr 0x%0h, expected no request", d_addr_o);
                end else begin
                    check("d_addr", d_addr_o, bus_exp[0].addr);
                    check("d_be", 64'(d_be_o), 64'(bus_exp[0].be));
                    check("d_data", d_data_o, bus_exp[0].data);
                    if (d_ack_i) void'(bus_exp.pop_front());
                end
            end
            hs = res_valid_o && res_ready_i;
            if (hs) begin
                if (res_exp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL res_unexpected: got result tag %0d, expected none", res_tag_o);
                end else begin
                    check("res_tag", 64'(res_tag_o), 64'(res_exp[0].tag));
                    check("res_err", 64'(res_err_o), 64'(res_exp[0].err));
                    void'(res_exp.pop_front());
                end
            end
            mv = commit_i && spec_q.size() > 0 && com_q.size() < CD;
            ps = st_valid_i && spec_q.size() < SD && !flush_i;
            if (mv) begin
                e = spec_q.pop_front();
                com_q.push_back(e);
                res_exp.push_back('{tag: e.tag, err: (e.ex ? 1'b1 : e.addr[4])});
                if (!e.ex) bus_exp.push_back(e);
            end
            if (flush_i) spec_q.delete();
            if (ps) spec_q.push_back('{addr: st_addr_i, be: model_be(st_addr_i, st_size_i),
                                       data: st_data_i, ex: st_ex_i, tag: st_tag_i});
            if (hs && com_q.size() > 0) void'(com_q.pop_front());
        end
    end

    // Bus/result responder; in auto mode the bus errors exactly when address bit 4 is set.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            d_ack_i = 1'b0;
            d_err_i = 1'b0;
        end else if (man_mode) begin
            d_ack_i     = man_ack;
            d_err_i     = man_err;
            res_ready_i = man_rdy;
        end else begin
            d_ack_i     = ($urandom_range(0, 9) < 4);
            d_err_i     = d_req_o ? d_addr_o[4] : 1'($urandom_range(0, 1));
            res_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d,
                        input logic ex, input logic [2:0] tag);
        st_valid_i = 1'b1; st_addr_i = a; st_size_i = sz; st_data_i = d; st_ex_i = ex; st_tag_i = tag;
        step();
        st_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int c = 0;
        st_valid_i = 1'b0; flush_i = 1'b0; commit_i = 1'b1;
        while ((spec_q.size() != 0 || com_q.size() != 0 || res_exp.size() != 0) && c < budget) begin
            step();
            c++;
        end
        commit_i = 1'b0;
        n_tests++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s: got %0d results outstanding after %0d cycles, expected 0",
                     name, res_exp.size(), budget);
        end
    endtask

    task automatic wait_req(input int budget, input string name);
        int c = 0;
        while (!d_req_o && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (!d_req_o) begin
            n_fail++;
            $display("FAIL %s: got d_req_o=0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_size_i = '0;
        st_data_i = '0; st_ex_i = 1'b0; st_tag_i = '0; commit_i = 1'b0;
        ld_addr_i = 64'h1000; ld_be_i = 8'hFF; res_ready_i = 1'b1; d_ack_i = 1'b0; d_err_i = 1'b0;
        #1;
        check("rst_st_ready", 64'(st_ready_o), 64'd1);
        check("rst_d_req", 64'(d_req_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_res_err", 64'(res_err_o), 64'd0);
        check("rst_ld_wait", 64'(ld_wait_o), 64'd0);
        check("rst_ld_fwd_valid", 64'(ld_fwd_valid_o), 64'd0);
        check("rst_outputs", d_addr_o | d_data_o | ld_fwd_data_o | 64'(d_be_o) | 64'(res_tag_o), 64'd0);
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 8-byte store forwarded to an upper-half load
        push(64'h1000, 2'd3, 64'hA1B2C3D4E5F60718, 1'b0, 3'd1);
        ld_addr_i = 64'h1004; ld_be_i = 8'hF0;
        @(negedge clk);
        check("fwd8_valid", 64'(ld_fwd_valid_o), 64'd1);
        check("fwd8_data", ld_fwd_data_o, 64'hA1B2C3D400000000);
        check("fwd8_wait", 64'(ld_wait_o), 64'd0);
        step(); flush_i = 1'b1; step(); flush_i = 1'b0;

        // partial overlap stalls, disjoint lanes pass
        push(64'h1003, 2'd0, 64'h0000000055000000, 1'b0, 3'd2);
        ld_addr_i = 64'h1000; ld_be_i = 8'h0F;
        @(negedge clk);
        check("partial_wait", 64'(ld_wait_o), 64'd1);
        check("partial_fwd", 64'(ld_fwd_valid_o), 64'd0);
        step(); ld_be_i = 8'hF0;
        @(negedge clk);
        check("disjoint_wait", 64'(ld_wait_o), 64'd0);
        check("disjoint_fwd", 64'(ld_fwd_valid_o), 64'd0);
        step(); flush_i = 1'b1; step(); flush_i = 1'b0;

        // fill, then flush together with commit
        for (int i = 0; i < SD; i++)
            push(64'h2000 + 64'(i * 8), 2'd3, {$urandom, $urandom}, 1'b0, 3'(i));
        @(negedge clk);
        check("full_ready", 64'(st_ready_o), 64'd0);
        step();
        flush_i = 1'b1; commit_i = 1'b1; step(); flush_i = 1'b0; commit_i = 1'b0;
        ld_addr_i = 64'h2000; ld_be_i = 8'hFF;
        @(negedge clk);
        check("flush_ready", 64'(st_ready_o), 64'd1);
        check("flush_kept_oldest", 64'(ld_fwd_valid_o), 64'd1);
        step(); ld_addr_i = 64'h2008;
        @(negedge clk);
        check("flush_dropped_fwd", 64'(ld_fwd_valid_o), 64'd0);
        check("flush_dropped_wait", 64'(ld_wait_o), 64'd0);
        drain(200, "drain_flush");

        // excepting store: no bus request, result two cycles after commit
        man_mode = 1'b1; man_rdy = 1'b1; man_ack = 1'b0; man_err = 1'b0;
        push(64'h3000, 2'd3, 64'h1234, 1'b1, 3'd5);
        commit_i = 1'b1; step(); commit_i = 1'b0;
        @(negedge clk);
        check("ex_early_valid", 64'(res_valid_o), 64'd0);
        step();
        @(negedge clk);
        check("ex_valid", 64'(res_valid_o), 64'd1);
        check("ex_tag", 64'(res_tag_o), 64'd5);
        check("ex_err", 64'(res_err_o), 64'd1);
        check("ex_no_req", 64'(d_req_o), 64'd0);
        step(); step();

        // slow bus ack with error, result back-pressure withholds the next request
        man_rdy = 1'b0;
        push(64'h2010, 2'd3, 64'hDEADBEEF00000001, 1'b0, 3'd1);
        push(64'h2020, 2'd3, 64'hDEADBEEF00000002, 1'b0, 3'd2);
        commit_i = 1'b1; step(); step(); commit_i = 1'b0;
        wait_req(20, "slow_req_start");
        for (int i = 0; i < 3; i++) begin
            check("slow_req_held", 64'(d_req_o), 64'd1);
            check("slow_addr_stable", d_addr_o, 64'h2010);
            step();
            @(negedge clk);
        end
        step();
        man_ack = 1'b1; man_err = 1'b1; step(); man_ack = 1'b0; man_err = 1'b0;
        @(negedge clk);
        check("slow_res_valid", 64'(res_valid_o), 64'd1);
        check("slow_res_err", 64'(res_err_o), 64'd1);
        check("slow_withheld0", 64'(d_req_o), 64'd0);
        step();
        @(negedge clk);
        check("slow_withheld1", 64'(d_req_o), 64'd0);
        man_mode = 1'b0; man_rdy = 1'b1;
        drain(200, "drain_slow");

        // asynchronous reset in the middle of a bus request
        man_mode = 1'b1; man_rdy = 1'b1; man_ack = 1'b0;
        push(64'h4000, 2'd3, 64'h0F0F, 1'b0, 3'd3);
        commit_i = 1'b1; step(); commit_i = 1'b0;
        wait_req(20, "rst_req_start");
        #1 rst_n = 1'b0;
        #1;
        check("midrst_d_req", 64'(d_req_o), 64'd0);
        check("midrst_st_ready", 64'(st_ready_o), 64'd1);
        check("midrst_d_addr", d_addr_o, 64'd0);
        spec_q.delete(); com_q.delete(); bus_exp.delete(); res_exp.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        man_ack = 1'b1; step(); step(); man_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_result", 64'(res_valid_o), 64'd0);
            check("postrst_no_req", 64'(d_req_o), 64'd0);
            step();
        end
        man_mode = 1'b0;

        // randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            st_valid_i = ($urandom_range(0, 9) < 6);
            st_addr_i  = 64'h5000 + 64'($urandom_range(0, 31));
            st_size_i  = 2'($urandom_range(0, 3));
            st_data_i  = {$urandom, $urandom};
            st_ex_i    = ($urandom_range(0, 7) == 0);
            st_tag_i   = 3'($urandom_range(0, 7));
            commit_i   = ($urandom_range(0, 9) < 4);
            flush_i    = ($urandom_range(0, 19) == 0);
            ld_addr_i  = 64'h5000 + 64'($urandom_range(0, 31));
            ld_be_i    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            step();
        end
        drain(500, "drain_random");
        check("final_bus_queue", 64'(bus_exp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameters: SPEC_DEPTH, default 4, speculative entries (>=2, power of 2); COMMIT_DEPTH, default 4, committed entries (>=2, power of 2); ADDR_W, default 64, physical address width; TAG_W, default 3, scoreboard tag width.
REQ-002 SHALL have ports:
- clk_i  in  1  clock; one clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard speculative entries.
- st_valid_i / st_ready_o  in/out  1  store push handshake.
- st_addr_i  in  ADDR_W  store physical address.
- st_size_i  in  2  store size: 0=1B, 1=2B, 2=4B, 3=8B.
- st_data_i  in  64  store data, byte lanes as on the bus.
- st_ex_i  in  1  store already carries an exception.
- st_tag_i  in  TAG_W  scoreboard tag.
- commit_i  in  1  commit the oldest speculative store.
- ld_addr_i  in  ADDR_W  probing load address.
- ld_be_i  in  8  probing load byte enables.
- ld_wait_o  out  1  load must stall.
- ld_fwd_valid_o  out  1  forward data valid.
- ld_fwd_data_o  out  64  forwarded bytes.
- d_req_o  out  1  bus store request.
- d_addr_o  out  ADDR_W  bus address.
- d_be_o  out  8  bus byte enables.
- d_data_o  out  64  bus data.
- d_ack_i  in  1  bus completion.
- d_err_i  in  1  bus error, valid with d_ack_i.
- res_valid_o / res_ready_i  out/in  1  result handshake.
- res_tag_o  out  TAG_W  result tag.
- res_err_o  out  1  store faulted.

Function
REQ-003 SHALL compute the byte mask at push: be = ((1<<(1<<size))-1) << addr[2:0], truncated to 8 bits; the entry stores addr, be, data, ex, tag, and a valid bit.
REQ-004 SHALL assert st_ready_o = ~spec_full; push occurs iff st_valid_i & st_ready_o & ~flush_i.
REQ-005 SHALL move the oldest speculative entry to the commit queue iff commit_i & ~spec_empty & ~commit_full; the move is not a bypass, so a store pushed in cycle N is committable from N+1; commit_i is ignored when its condition is false.
REQ-006 SHALL on flush_i clear all speculative entries in the same cycle, but REQ-005 takes priority: the oldest entry moves to the commit queue first. Committed entries and the bus FSM are never flushed.
REQ-007 SHALL run a drain FSM on the commit-queue head:
- IDLE -> REQ when the head is valid and ex=0.
- IDLE -> RESP when the head is valid and ex=1; no bus request is made and err=1.
- REQ: d_req_o=1, with d_addr_o/d_be_o/d_data_o equal to the head entry, held stable until d_ack_i. On d_ack_i -> RESP, registering err=d_err_i.
- RESP: res_valid_o=1, res_tag_o=head tag, res_err_o=err. On res_ready_i, pop the head -> IDLE.
REQ-008 SHALL leave d_ack_i ignored outside REQ and allow at most one outstanding bus request.
REQ-009 SHALL give a store with no exception a minimum latency of 1 cycle (IDLE->REQ) + bus latency + 1 cycle (RESP) from reaching the commit head to res_valid_o.
REQ-010 SHALL define overlap of a valid entry with the probing load as entry.addr[ADDR_W-1:3]==ld_addr_i[ADDR_W-1:3] and (entry.be & ld_be_i)!=0; this check is combinational.
REQ-011 SHALL select the youngest overlapping entry, searching speculative newest-to-oldest, then committed newest-to-oldest. If that entry has ex=0 and (entry.be & ld_be_i)==ld_be_i, then ld_fwd_valid_o=1, ld_wait_o=0, and ld_fwd_data_o=entry.data masked to ld_be_i (other bytes 0).
REQ-012 SHALL otherwise set ld_wait_o = any overlap, ld_fwd_valid_o=0 and ld_fwd_data_o=0; with ld_be_i=0, both outputs are 0.
REQ-013 SHALL keep pointer wrap-around correct for any depth and distinguish full from empty with an extra pointer bit per queue.

Reset
REQ-014 SHALL on rst_ni=0 asynchronously empty both queues and force the FSM to IDLE.
REQ-015 SHALL hold these values during reset: st_ready_o=1, d_req_o=0, res_valid_o=0, res_err_o=0, ld_wait_o=0, ld_fwd_valid_o=0, and all data/tag/address outputs 0.
REQ-016 SHALL, on reset assertion mid-bus-transaction, drop d_req_o immediately and ignore any later d_ack_i while in IDLE.

Verification
REQ-017 Push an 8B store at 0x1000 with data 0xA1B2C3D4E5F60718, then probe ld_addr=0x1004 with ld_be=0xF0 -> ld_fwd_valid_o=1, ld_fwd_data_o=0xA1B2C3D400000000, ld_wait_o=0.
REQ-018 Push a 1B store at 0x1003, then probe ld_addr=0x1000 with ld_be=0x0F -> ld_wait_o=1, ld_fwd_valid_o=0. Probe ld_be=0xF0 -> both outputs 0.
REQ-019 Fill SPEC_DEPTH stores -> st_ready_o=0. Pulse flush_i together with commit_i -> exactly one entry in the commit queue, spec empty, st_ready_o=1 the next cycle.
REQ-020 Commit a store with st_ex_i=1, tag 5 -> d_req_o is never asserted; res_valid_o=1, res_tag_o=5, res_err_o=1 two cycles after commit.
REQ-021 Commit two stores, hold d_ack_i=0 for 3 cycles, then ack with d_err_i=1 -> d_req_o stays high with stable address throughout; first result has err=1; with res_ready_i low for 2 cycles, the second request is withheld.
REQ-022 Assert rst_ni=0 while in REQ -> d_req_o=0 and st_ready_o=1 without a clock edge; an ack after release produces no result.
